// File: rtl/imm_extend_pipe_if.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : imm_extend_pipe_if
// Brief    : Request/result channel bundle for the immediate extension pipe.
//            master = requester/consumer side, slave = the extension pipe.
// Revision : 1.0 - initial release
// ============================================================================
interface imm_extend_pipe_if #(
  parameter int IN_W  = 16,
  parameter int OUT_W = 32
);

  // Request channel
  logic             in_valid;
  logic             in_ready;
  logic [IN_W-1:0]  in_data;
  logic [1:0]       in_mode;

  // Result channel
  logic             out_valid;
  logic             out_ready;
  logic [OUT_W-1:0] out_data;
  logic [1:0]       out_mode;

  modport master (
    output in_valid,
    output in_data,
    output in_mode,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  out_data,
    input  out_mode
  );

  modport slave (
    input  in_valid,
    input  in_data,
    input  in_mode,
    input  out_ready,
    output in_ready,
    output out_valid,
    output out_data,
    output out_mode
  );

endinterface
`default_nettype wire

// File: rtl/imm_extend_pipe.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : imm_extend_pipe
// Brief    : Immediate sign/zero/branch/upper extension with a two-entry
//            skid buffer on the output. The result is computed from the
//            request as it is accepted and stored, so later input changes
//            never affect a buffered result.
// Revision : 1.0 - initial release
// ============================================================================
module imm_extend_pipe #(
  parameter int IN_W     = 16,
  parameter int OUT_W    = 32,
  parameter int BR_SHIFT = 2
) (
  input  wire logic         clk,
  input  wire logic         reset_n,
  imm_extend_pipe_if.slave  bus
);

  localparam int EXT_W = OUT_W - IN_W;

  localparam logic [1:0] MODE_SEXT  = 2'b00;
  localparam logic [1:0] MODE_ZEXT  = 2'b01;
  localparam logic [1:0] MODE_BRANCH = 2'b10;

  // Buffer occupancy states
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic             in_ready_q, in_ready_d;
  logic [OUT_W-1:0] head_data_q, head_data_d;
  logic [1:0]       head_mode_q, head_mode_d;
  logic [OUT_W-1:0] tail_data_q, tail_data_d;
  logic [1:0]       tail_mode_q, tail_mode_d;

  logic [OUT_W-1:0] sext_val;
  logic [OUT_W-1:0] zext_val;
  logic [OUT_W-1:0] branch_val;
  logic [OUT_W-1:0] upper_val;
  logic [OUT_W-1:0] ext_val;
  logic             accept;
  logic             drain;
  logic             out_valid;

  // ---------------------------------------------------------------------------
  // Extension datapath (purely a function of the request currently offered)
  // ---------------------------------------------------------------------------
  assign sext_val   = {{EXT_W{bus.in_data[IN_W-1]}}, bus.in_data};
  assign zext_val   = {{EXT_W{1'b0}}, bus.in_data};
  assign branch_val = sext_val << BR_SHIFT;
  assign upper_val  = {bus.in_data, {EXT_W{1'b0}}};

  // Select the extension flavour requested by in_mode
  always_comb begin
    ext_val = upper_val;
    case (bus.in_mode)
      MODE_SEXT:   ext_val = sext_val;
      MODE_ZEXT:   ext_val = zext_val;
      MODE_BRANCH: ext_val = branch_val;
      default:     ext_val = upper_val;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Handshake qualifiers. in_ready comes straight from a flop so that the
  // request side never sees a path from out_ready.
  // ---------------------------------------------------------------------------
  assign out_valid = (state_q != ST_EMPTY);
  assign accept    = bus.in_valid & in_ready_q;
  assign drain     = out_valid & bus.out_ready;

  // Next-state and buffer update logic for the skid buffer
  always_comb begin
    state_d     = state_q;
    head_data_d = head_data_q;
    head_mode_d = head_mode_q;
    tail_data_d = tail_data_q;
    tail_mode_d = tail_mode_q;

    case (state_q)
      ST_EMPTY: begin
        if (accept) begin
          head_data_d = ext_val;
          head_mode_d = bus.in_mode;
          state_d     = ST_ONE;
        end
      end

      ST_ONE: begin
        if (accept && !drain) begin
          // Head stays put; the newcomer waits behind it
          tail_data_d = ext_val;
          tail_mode_d = bus.in_mode;
          state_d     = ST_TWO;
        end else if (accept && drain) begin
          // Head leaves on this edge, so the newcomer takes its place
          head_data_d = ext_val;
          head_mode_d = bus.in_mode;
          state_d     = ST_ONE;
        end else if (drain) begin
          state_d     = ST_EMPTY;
        end
      end

      ST_TWO: begin
        // in_ready is low here, so only a drain can change anything
        if (drain) begin
          head_data_d = tail_data_q;
          head_mode_d = tail_mode_q;
          state_d     = ST_ONE;
        end
      end

      default: begin
        state_d = ST_EMPTY;
      end
    endcase

    in_ready_d = (state_d != ST_TWO);
  end

  // State register; reset holds in_ready low so the first edge after release
  // only raises in_ready and never transfers a request
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_EMPTY;
      in_ready_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      in_ready_q <= in_ready_d;
    end
  end

  // Buffer storage; cleared on reset so no stale result can be presented
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      head_data_q <= '0;
      head_mode_q <= '0;
      tail_data_q <= '0;
      tail_mode_q <= '0;
    end else begin
      head_data_q <= head_data_d;
      head_mode_q <= head_mode_d;
      tail_data_q <= tail_data_d;
      tail_mode_q <= tail_mode_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs: the head entry is always the oldest buffered result
  // ---------------------------------------------------------------------------
  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid;
  assign bus.out_data  = head_data_q;
  assign bus.out_mode  = head_mode_q;

endmodule
`default_nettype wire

// File: tb/tb_imm_extend_pipe.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_imm_extend_pipe
// Brief    : Self-checking bench for imm_extend_pipe. Expected results come
//            from an arithmetic reference of the extension rules and a FIFO
//            of accepted requests.
// Revision : 1.0 - initial release
// ============================================================================
module tb_imm_extend_pipe;

  localparam int IN_W     = 16;
  localparam int OUT_W    = 32;
  localparam int BR_SHIFT = 2;

  logic clk;
  logic reset_n;

  int total;
  int bad;

  imm_extend_pipe_if #(.IN_W(IN_W), .OUT_W(OUT_W)) bus ();

  imm_extend_pipe #(
    .IN_W     (IN_W),
    .OUT_W    (OUT_W),
    .BR_SHIFT (BR_SHIFT)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point for the whole bench
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference: extension rules evaluated with signed integer arithmetic
  function automatic logic [OUT_W-1:0] ref_ext(input logic [IN_W-1:0] d, input logic [1:0] m);
    longint u;
    longint s;
    longint r;
    u = longint'(d);
    s = d[IN_W-1] ? (u - (longint'(1) << IN_W)) : u;
    case (m)
      2'b00:   r = s;
      2'b01:   r = u;
      2'b10:   r = s * (longint'(1) << BR_SHIFT);
      default: r = u * (longint'(1) << (OUT_W - IN_W));
    endcase
    return r[OUT_W-1:0];
  endfunction

  // ---------------------------------------------------------------------------
  // Scoreboard / monitor, sampled on the falling edge
  // ---------------------------------------------------------------------------
  logic [OUT_W+1:0] exp_q[$];
  int               n_acc;
  int               n_out;
  bit               cold;
  bit               hold_v;
  logic [OUT_W-1:0] hold_d;
  logic [1:0]       hold_m;

  initial begin
    int occ;
    logic [OUT_W+1:0] e;
    n_acc = 0; n_out = 0; cold = 1'b1; hold_v = 1'b0;
    hold_d = '0; hold_m = '0;
    forever begin
      @(negedge clk);
      if (reset_n) begin
        occ = exp_q.size();
        chk("mon_out_valid", 64'(bus.out_valid), 64'(occ > 0));
        chk("mon_in_ready", 64'(bus.in_ready), cold ? 64'd0 : 64'(occ < 2));
        cold = 1'b0;
        if (hold_v) begin
          chk("stall_data", 64'(bus.out_data), 64'(hold_d));
          chk("stall_mode", 64'(bus.out_mode), 64'(hold_m));
        end
        if (bus.out_valid && bus.out_ready && occ > 0) begin
          e = exp_q.pop_front();
          chk("out_data", 64'(bus.out_data), 64'(e[OUT_W-1:0]));
          chk("out_mode", 64'(bus.out_mode), 64'(e[OUT_W+1:OUT_W]));
          n_out++;
        end
        hold_v = bus.out_valid && !bus.out_ready;
        hold_d = bus.out_data;
        hold_m = bus.out_mode;
        if (bus.in_valid && bus.in_ready) begin
          exp_q.push_back({bus.in_mode, ref_ext(bus.in_data, bus.in_mode)});
          n_acc++;
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers (all drives happen 1ns after a rising edge)
  // ---------------------------------------------------------------------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [IN_W-1:0] d, input logic [1:0] m);
    bit got;
    got = 1'b0;
    tick();
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    bus.in_mode  = m;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (bus.in_ready) begin
        got = 1'b1;
        break;
      end
    end
    if (!got) chk("send_timeout", 64'd0, 64'd1);
    tick();
    bus.in_valid = 1'b0;
  endtask

  task automatic model_reset();
    exp_q.delete();
    hold_v = 1'b0;
    cold   = 1'b1;
  endtask

  // ---------------------------------------------------------------------------
  // Main sequence
  // ---------------------------------------------------------------------------
  initial begin
    logic [IN_W-1:0] a, b, c;
    logic [1:0]      ma, mb, mc;
    int              base_acc;
    int              base_out;
    bit              ok;

    total = 0;
    bad   = 0;
    reset_n       = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_data   = 16'h8001;
    bus.in_mode   = 2'b00;
    bus.out_ready = 1'b1;

    // Reset values
    #12;
    chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_in_ready",  64'(bus.in_ready),  64'd0);
    chk("rst_out_data",  64'(bus.out_data),  64'd0);
    chk("rst_out_mode",  64'(bus.out_mode),  64'd0);

    // Release with a request pending: the first edge must not transfer
    @(posedge clk);
    #1;
    model_reset();
    reset_n = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("first_edge_no_xfer", 64'(bus.out_valid), 64'd0);
    chk("first_edge_ready",   64'(bus.in_ready),  64'd1);
    tick();
    bus.in_valid = 1'b0;
    repeat (3) tick();

    // Directed mode checks, one cycle after acceptance
    begin
      logic [IN_W-1:0]  dd [6] = '{16'h8001, 16'h8001, 16'h8001, 16'h8001, 16'h7FFF, 16'h7FFF};
      logic [1:0]       mm [6] = '{2'b00, 2'b01, 2'b10, 2'b11, 2'b00, 2'b10};
      logic [OUT_W-1:0] ee [6] = '{32'hFFFF8001, 32'h00008001, 32'hFFFE0004,
                                   32'h80010000, 32'h00007FFF, 32'h0001FFFC};
      for (int i = 0; i < 6; i++) begin
        send(dd[i], mm[i]);
        @(negedge clk);
        chk("dir_valid", 64'(bus.out_valid), 64'd1);
        chk("dir_data",  64'(bus.out_data),  64'(ee[i]));
        chk("dir_mode",  64'(bus.out_mode),  64'(mm[i]));
      end
    end
    repeat (2) tick();

    // Back-pressure: A and B fill the buffer, C is held off
    a = IN_W'($urandom); b = IN_W'($urandom); c = IN_W'($urandom);
    ma = 2'($urandom); mb = 2'($urandom); mc = 2'($urandom);
    base_out = n_out;
    tick();
    bus.out_ready = 1'b0;
    bus.in_valid = 1'b1; bus.in_data = a; bus.in_mode = ma;
    tick();
    bus.in_data = b; bus.in_mode = mb;
    tick();
    bus.in_data = c; bus.in_mode = mc;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("bp_in_ready", 64'(bus.in_ready), 64'd0);
      chk("bp_head",     64'(bus.out_data), 64'(ref_ext(a, ma)));
    end
    tick();
    bus.out_ready = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.in_ready) begin
        ok = 1'b1;
        break;
      end
    end
    chk("bp_c_accept", 64'(ok), 64'd1);
    tick();
    bus.in_valid = 1'b0;
    repeat (4) tick();
    chk("bp_out_count", 64'(n_out - base_out), 64'd3);

    // Streaming: 100 requests back to back with the consumer always ready
    base_acc = n_acc;
    base_out = n_out;
    for (int i = 0; i < 100; i++) begin
      bus.in_valid = 1'b1;
      bus.in_data  = IN_W'($urandom);
      bus.in_mode  = 2'($urandom);
      tick();
    end
    bus.in_valid = 1'b0;
    repeat (3) tick();
    chk("stream_acc", 64'(n_acc - base_acc), 64'd100);
    chk("stream_out", 64'(n_out - base_out), 64'd100);

    // Random valid/ready toggling
    base_acc = n_acc;
    base_out = n_out;
    for (int i = 0; i < 1000; i++) begin
      bus.in_valid  = 1'($urandom);
      bus.in_data   = IN_W'($urandom);
      bus.in_mode   = 2'($urandom);
      bus.out_ready = ($urandom_range(0, 3) != 0);
      tick();
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    repeat (5) tick();
    chk("rand_balance", 64'(n_out - base_out), 64'(n_acc - base_acc));
    chk("rand_empty",   64'(exp_q.size()), 64'd0);

    // Asynchronous reset while holding two entries
    bus.out_ready = 1'b0;
    send(IN_W'($urandom), 2'($urandom));
    send(IN_W'($urandom), 2'($urandom));
    @(negedge clk);
    chk("two_full", 64'(bus.in_ready), 64'd0);
    @(posedge clk);
    #3;
    reset_n = 1'b0;
    #1;
    chk("async_out_valid", 64'(bus.out_valid), 64'd0);
    chk("async_in_ready",  64'(bus.in_ready),  64'd0);
    chk("async_out_data",  64'(bus.out_data),  64'd0);
    model_reset();
    bus.out_ready = 1'b1;
    repeat (2) tick();
    reset_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("post_rst_no_stale", 64'(bus.out_valid), 64'd0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Global bound on run time
  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire

// File: doc/imm_extend_pipe.md
IMM_EXTEND_PIPE -- requirements
Module: imm_extend_pipe

Interface
REQ-001 Parameter IN_W, default 16, immediate input width.
REQ-002 Parameter OUT_W, default 32, extended output width; IN_W < OUT_W required; other values unsupported.
REQ-003 Parameter BR_SHIFT, default 2, left shift applied in branch-offset mode; 0 <= BR_SHIFT < OUT_W.
REQ-004 Port clk  input  1  single clock; all state updates on rising edge.
REQ-005 Port reset_n  input  1  asynchronous active-low reset.
REQ-006 Port in_valid  input  1  in_data/in_mode hold a valid request.
REQ-007 Port in_ready  output  1  block accepts a request this cycle.
REQ-008 Port in_data  input  IN_W  raw immediate field.
REQ-009 Port in_mode  input  2  00 sign-extend, 01 zero-extend, 10 sign-extend then shift left BR_SHIFT, 11 upper-place (in_data in bits OUT_W-1..OUT_W-IN_W, lower bits zero).
REQ-010 Port out_valid  output  1  out_data holds a valid result.
REQ-011 Port out_ready  input  1  consumer accepts out_data this cycle.
REQ-012 Port out_data  output  OUT_W  extended result.
REQ-013 Port out_mode  output  2  mode of the request that produced out_data.

Function
REQ-014 Transfer occurs on an input edge when in_valid and in_ready are both 1; on an output edge when out_valid and out_ready are both 1.
REQ-015 Mode 00: out = {(OUT_W-IN_W) copies of in_data[IN_W-1], in_data}.
REQ-016 Mode 01: out = {(OUT_W-IN_W) zeros, in_data}.
REQ-017 Mode 10: out = (mode-00 result << BR_SHIFT) truncated to OUT_W bits, vacated low bits zero.
REQ-018 Mode 11: out = {in_data, (OUT_W-IN_W) zeros}.
REQ-019 Extension computed combinationally at input and captured at the accepting edge; results never recomputed from later input values.
REQ-020 Latency: result accepted at edge N is presented with out_valid=1 after edge N; no combinational path from in_* to out_*.
REQ-021 Storage: two-entry skid buffer, states EMPTY, ONE, TWO; out_data/out_mode always come from the oldest entry.
REQ-022 EMPTY: out_valid=0, in_ready=1; accept -> ONE.
REQ-023 ONE: out_valid=1, in_ready=1; accept without drain -> TWO; drain without accept -> EMPTY; accept and drain same edge -> ONE, new entry becomes head.
REQ-024 TWO: out_valid=1, in_ready=0; drain -> ONE, second entry becomes head; in_valid ignored.
REQ-025 in_ready is a registered function of state only, independent of out_ready in the same cycle.
REQ-026 Sustained in_valid=1 and out_ready=1 gives one result per cycle, in order, none dropped or duplicated.
REQ-027 out_data and out_mode stable while out_valid=1 and out_ready=0.
REQ-028 in_mode/in_data ignored when in_valid=0 or in_ready=0.

Reset
REQ-029 reset_n=0 forces state EMPTY immediately, independent of clk.
REQ-030 During reset: out_valid=0, in_ready=0, out_data=0, out_mode=00.
REQ-031 First edge after reset_n rises: in_ready=1 (state EMPTY), no transfer on that edge.
REQ-032 Reset mid-operation discards all buffered entries; no stale result emitted afterwards.

Verification
REQ-033 Defaults, out_ready=1: in_data=16'h8001 in modes 00/01/10/11 -> 32'hFFFF8001, 32'h00008001, 32'hFFFE0004, 32'h80010000, each one cycle after acceptance.
REQ-034 in_data=16'h7FFF mode 00 -> 32'h00007FFF; mode 10 -> 32'h0001FFFC.
REQ-035 Back-pressure: out_ready=0, three back-to-back requests A,B,C -> A,B buffered, in_ready=0 after second accept, C held; out_ready=1 -> A,B,C out in order, stable while stalled.
REQ-036 Streaming: 100 random requests, in_valid=1, out_ready=1 -> 100 results one per cycle matching a reference model, in order.
REQ-037 Random in_valid/out_ready toggling, 1000 cycles -> every accepted request emitted exactly once, in order, out_data stable under stall.
REQ-038 Assert reset_n=0 asynchronously in state TWO -> out_valid=0 without a clock edge; after release no pre-reset entry appears.
